// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_CNT_W = 5;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    function automatic logic op_is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_iter_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           ge;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : (WIDTH + 1)'(0));
        shifted = {hi, lo[WIDTH-1]};
        ge      = shifted >= {1'b0, b};
        hi_n    = sum[WIDTH:1];
        lo_n    = {sum[0], lo[WIDTH-1:1]};
        if (is_div) begin
            // Remainder fits in WIDTH bits after a successful subtract.
            hi_n = ge ? WIDTH'(shifted - {1'b0, b}) : shifted[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing a single-cycle HI/LO commit.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    md_state_t        state, state_nx;
    md_op_t           op_in, op_r;
    logic             sgn_q, sgn_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opd_b;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             in_signed, in_div, div_zero, accept, last;

    assign op_in     = md_op_t'(op);
    assign in_signed = op_is_signed(op_in);
    assign in_div    = op_is_div(op_in);
    assign abs_a     = (in_signed && src_a[WIDTH-1]) ? WIDTH'(-src_a) : src_a;
    assign abs_b     = (in_signed && src_b[WIDTH-1]) ? WIDTH'(-src_b) : src_b;
    assign div_zero  = in_div && (src_b == '0);
    assign accept    = (state == MD_IDLE) && start && !flush;
    assign last      = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        case (state)
            MD_IDLE: begin
                stall = start;
                if (accept) state_nx = div_zero ? MD_DONE : MD_BUSY;
            end
            MD_BUSY: begin
                stall = 1'b1;
                if (flush)     state_nx = MD_IDLE;
                else if (last) state_nx = MD_DONE;
            end
            MD_DONE: state_nx = MD_IDLE;
            default: state_nx = MD_IDLE;
        endcase
    end

    assign hi_we = (state == MD_DONE) && !flush;
    assign lo_we = hi_we;

    muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div (op_is_div(op_r)),
        .hi     (acc_hi),
        .lo     (acc_lo),
        .b      (opd_b),
        .hi_n   (step_hi),
        .lo_n   (step_lo)
    );

    // Sign correction of the final iteration's result.
    always_comb begin
        res_hi = step_hi;
        res_lo = step_lo;
        if (op_is_signed(op_r)) begin
            if (!op_is_div(op_r)) begin
                if (sgn_q) {res_hi, res_lo} = (2 * WIDTH)'(-{step_hi, step_lo});
            end else begin
                if (sgn_q) res_lo = WIDTH'(-step_lo);
                if (sgn_r) res_hi = WIDTH'(-step_hi);
            end
        end
    end

    // Multiply keeps the multiplier in acc_lo; divide keeps the dividend there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r   <= MD_MULT;
            sgn_q  <= 1'b0;
            sgn_r  <= 1'b0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opd_b  <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else if (accept) begin
            op_r   <= op_in;
            sgn_q  <= in_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            sgn_r  <= in_signed && src_a[WIDTH-1];
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= in_div ? abs_a : abs_b;
            opd_b  <= in_div ? abs_b : abs_a;
            if (div_zero) begin
                hi_o <= src_a;
                lo_o <= '1;
            end
        end else if (state == MD_BUSY && !flush) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                hi_o <= res_hi;
                lo_o <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv with a cycle-timed arithmetic reference model.
module tb_hilo_muldiv;

    localparam int unsigned WIDTH = 32;

    logic        clk, rst, start, flush;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        stall, hi_we, lo_we;
    logic [31:0] hi_o, lo_o;

    int total = 0;
    int bad   = 0;

    hilo_muldiv dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .stall (stall),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .hi_o  (hi_o),
        .lo_o  (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        case (o)
            2'b00:   return 64'(sa * sb);
            2'b01:   return ua * ub;
            2'b10:   return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            default: return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
        endcase
    endfunction

    // Model: m_wait counts busy cycles left, m_done marks the commit cycle.
    int          m_wait;
    logic        m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_wait > 0) begin
            if (flush) m_wait <= 0;
            else begin
                m_wait <= m_wait - 1;
                if (m_wait == 1) begin
                    m_done <= 1'b1;
                    m_hi   <= pend[63:32];
                    m_lo   <= pend[31:0];
                end
            end
        end else if (start && !flush) begin
            pend <= ref_result(op, src_a, src_b);
            if (op[1] && src_b == 0) begin
                m_done <= 1'b1;
                m_hi   <= src_a;
                m_lo   <= 32'hFFFF_FFFF;
            end else begin
                m_wait <= WIDTH;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_stall", 64'(stall), 64'((m_wait > 0) ? 1'b1 : (m_done ? 1'b0 : start)));
            chk("cyc_hi_we", 64'(hi_we), 64'(m_done && !flush));
            chk("cyc_lo_we", 64'(lo_we), 64'(m_done && !flush));
            chk("cyc_hi_o", 64'(hi_o), 64'(m_hi));
            chk("cyc_lo_o", 64'(lo_o), 64'(m_lo));
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int estall,
                          input string nm);
        int n;
        bit seen;
        @(posedge clk); #1;
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(negedge clk);
        n = int'(stall);
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (hi_we) seen = 1'b1;
            else n += int'(stall);
        end
        chk({nm, "_pulse"}, 64'(seen), 64'(1));
        chk({nm, "_hi"}, 64'(hi_o), 64'(ehi));
        chk({nm, "_lo"}, 64'(lo_o), 64'(elo));
        chk({nm, "_stall_cycles"}, 64'(n), 64'(estall));
    endtask

    initial begin
        bit any_we;
        rst = 1'b1; start = 1'b1; flush = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        #3;
        chk("rst_hi_o", 64'(hi_o), 64'(0));
        chk("rst_lo_o", 64'(lo_o), 64'(0));
        chk("rst_we", 64'({hi_we, lo_we}), 64'(0));
        chk("rst_stall_start1", 64'(stall), 64'(1));
        start = 1'b0;
        #1;
        chk("rst_stall_start0", 64'(stall), 64'(0));
        #8 rst = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mult_m1x2");
        run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 33, "multu");
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33, "multu_2p32");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, "divu_100_7");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_m7_2");
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33, "div_7_m2");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, "div_ovf");
        run_op(2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1, "divu_by0");
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, "div_by0");

        // flush together with start in IDLE must not launch anything
        @(posedge clk); #1;
        op = 2'b00; src_a = 32'd3; src_b = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_stall", 64'(stall), 64'(0));

        // flush on the 10th busy cycle
        @(posedge clk); #1;
        op = 2'b00; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_stall", 64'(stall), 64'(0));
        any_we = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (hi_we || lo_we) any_we = 1'b1;
        end
        chk("flush_no_we", 64'(any_we), 64'(0));
        chk("flush_hi_kept", 64'(hi_o), 64'hFFFF_FFFB);
        chk("flush_lo_kept", 64'(lo_o), 64'hFFFF_FFFF);

        // asynchronous reset in the middle of a divide
        @(posedge clk); #1;
        op = 2'b10; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_hi_o", 64'(hi_o), 64'(0));
        chk("arst_lo_o", 64'(lo_o), 64'(0));
        chk("arst_stall", 64'(stall), 64'(0));
        chk("arst_we", 64'({hi_we, lo_we}), 64'(0));
        #1 rst = 1'b0;
        run_op(2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 33, "divu_9_3");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
